seg7_reader: RTL and testbench

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_to_bcd.sv | 33 +++
 rtl/seg7_reader.sv | 167 ++++++++++++++++
 tb/tb_seg7_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and reader FSM state type.
// Segment bit order is {a,b,c,d,e,f,g}, i.e. bit6=a ... bit0=g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_BAD   = 4'hE;

  typedef enum logic [1:0] {
    StSync    = 2'd0,
    StCollect = 2'd1,
    StHold    = 2'd2
  } rd_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment pattern to BCD decoder; inverse of the BCD-to-7-segment
// encoder. Blank decodes to BCD_BLANK, anything unrecognised to BCD_BAD with illegal_o set.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       illegal_o
);

  always_comb begin
    bcd_o     = BCD_BAD;
    illegal_o = 1'b0;
    case (seg_i)
      SEG_0:     bcd_o = 4'd0;
      SEG_1:     bcd_o = 4'd1;
      SEG_2:     bcd_o = 4'd2;
      SEG_3:     bcd_o = 4'd3;
      SEG_4:     bcd_o = 4'd4;
      SEG_5:     bcd_o = 4'd5;
      SEG_6:     bcd_o = 4'd6;
      SEG_7:     bcd_o = 4'd7;
      SEG_8:     bcd_o = 4'd8;
      SEG_9:     bcd_o = 4'd9;
      SEG_BLANK: bcd_o = BCD_BLANK;
      default: begin
        bcd_o     = BCD_BAD;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads a multiplexed seven-segment display: synchronizes and debounces the strobes,
// assembles one digit per stable dwell into a frame, and hands frames out valid/ready.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    out_ready,
  input  logic                    ovr_clr,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    out_valid,
  output logic                    frame_err,
  output logic                    overrun
);

  localparam int unsigned PW          = 7 + NUM_DIGITS;
  localparam int unsigned IW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);

  logic [PW-1:0]           meta_q, meta_d, sync_q, sync_d, last_q, last_d;
  logic [7:0]              cnt_q, cnt_d;
  rd_state_e               state_q, state_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d, err_q, err_d;
  logic [4*NUM_DIGITS-1:0] work_q, work_d, bcd_q, bcd_d;
  logic                    valid_q, valid_d, frame_err_q, frame_err_d, ovr_q, ovr_d;

  logic [NUM_DIGITS-1:0] sync_dig;
  logic [IW-1:0]         cap_idx;
  logic                  same, onehot, capture, cap0, hs, store, ovr_set;
  logic [3:0]            dec_bcd;
  logic                  dec_illegal;

  assign sync_dig = sync_q[NUM_DIGITS-1:0];
  assign same     = (sync_q == last_q);
  assign onehot   = (sync_dig != '0) && ((sync_dig & (sync_dig - 1'b1)) == '0);
  // Run length of the current synced pair is cnt_q+1; fire exactly when it reaches the target.
  assign capture  = same && (cnt_q == STABLE_LAST) && onehot;
  assign cap0     = capture && (cap_idx == '0);
  assign hs       = valid_q && out_ready;

  seg7_to_bcd u_dec (
    .seg_i     (sync_q[PW-1:NUM_DIGITS]),
    .bcd_o     (dec_bcd),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    cap_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (sync_dig[i]) cap_idx = IW'(i);
    end
  end

  always_comb begin
    meta_d = {seg, dig_en};
    sync_d = meta_q;
    last_d = sync_q;
    if (!same)                   cnt_d = 8'd1;
    else if (cnt_q < STABLE_MAX) cnt_d = cnt_q + 8'd1;
    else                         cnt_d = cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    err_d       = err_q;
    work_d      = work_q;
    bcd_d       = bcd_q;
    frame_err_d = frame_err_q;
    valid_d     = valid_q;
    ovr_d       = ovr_q;
    store       = 1'b0;
    ovr_set     = 1'b0;
    unique case (state_q)
      StSync: begin
        if (cap0) begin
          mask_d  = '0;
          err_d   = '0;
          store   = 1'b1;
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (capture) begin
          if (!mask_q[cap_idx]) begin
            store = 1'b1;
          end else if (cap0) begin
            mask_d = '0;
            err_d  = '0;
            store  = 1'b1;
          end else begin
            mask_d  = '0;
            state_d = StSync;
          end
        end
      end
      StHold: begin
        if (hs) begin
          valid_d = 1'b0;
          mask_d  = '0;
          state_d = StSync;
        end else if (cap0) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = StSync;
    endcase

    if (store) begin
      mask_d[cap_idx]                 = 1'b1;
      err_d[cap_idx]                  = dec_illegal;
      work_d[4*int'(cap_idx) +: 4]    = dec_bcd;
    end
    // Also covers the single-digit case, where the digit-0 capture in StSync completes the frame.
    if (store && (&mask_d)) begin
      bcd_d       = work_d;
      frame_err_d = |err_d;
      valid_d     = 1'b1;
      state_d     = StHold;
    end

    if (ovr_set)      ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q      <= '0;
      sync_q      <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      state_q     <= StSync;
      mask_q      <= '0;
      err_q       <= '0;
      work_q      <= '0;
      bcd_q       <= '0;
      frame_err_q <= 1'b0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
      work_q      <= work_d;
      bcd_q       <= bcd_d;
      frame_err_q <= frame_err_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bcd       = bcd_q;
  assign out_valid = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: directed scenarios plus randomized frames,
// compared against a frame-level reference model built from the decode table.
module tb_seg7_reader;

  localparam int N  = 4;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   seg;
  logic [N-1:0] dig_en;
  logic         out_ready;
  logic         ovr_clr;
  logic [4*N-1:0] bcd;
  logic         out_valid;
  logic         frame_err;
  logic         overrun;

  always #5 clk = ~clk;

  seg7_reader #(
    .NUM_DIGITS    (N),
    .STABLE_CYCLES (ST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seg       (seg),
    .dig_en    (dig_en),
    .out_ready (out_ready),
    .ovr_clr   (ovr_clr),
    .bcd       (bcd),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: frame assembly at the level of whole captures.
  logic [6:0]     pat_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                   7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  bit             m_collecting, m_holding, m_ovr, m_ferr;
  bit             m_seen [N];
  logic [3:0]     m_dig  [N];
  logic [4*N-1:0] m_bcd;

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    for (int k = 0; k < 10; k++) if (pat_tab[k] == p) return 4'(k);
    if (p == 7'h00) return 4'hF;
    return 4'hE;
  endfunction

  function automatic void model_reset();
    m_collecting = 0; m_holding = 0; m_ovr = 0; m_ferr = 0; m_bcd = '0;
    for (int d = 0; d < N; d++) m_seen[d] = 0;
  endfunction

  function automatic void model_capture(input int d, input logic [6:0] p);
    bit all;
    if (m_holding) begin
      if (d == 0) m_ovr = 1;
      return;
    end
    if (!m_collecting) begin
      if (d != 0) return;
      m_collecting = 1;
      for (int k = 0; k < N; k++) m_seen[k] = 0;
    end else if (m_seen[d]) begin
      if (d != 0) begin
        m_collecting = 0;
        return;
      end
      for (int k = 0; k < N; k++) m_seen[k] = 0;
    end
    m_seen[d] = 1;
    m_dig[d]  = ref_decode(p);
    all = 1;
    for (int k = 0; k < N; k++) all &= m_seen[k];
    if (all) begin
      m_collecting = 0;
      m_holding    = 1;
      m_ferr       = 0;
      for (int k = 0; k < N; k++) begin
        m_bcd[4*k +: 4] = m_dig[k];
        if (m_dig[k] == 4'hE) m_ferr = 1;
      end
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dwell(input int d, input logic [6:0] p, input int len);
    seg = p;
    dig_en = '0;
    dig_en[d] = 1'b1;
    repeat (len) cyc();
    if (len >= ST) model_capture(d, p);
  endtask

  task automatic quiet(input int len);
    seg = '0;
    dig_en = '0;
    repeat (len) cyc();
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                      input logic [6:0] p3, input int len);
    dwell(0, p0, len); dwell(1, p1, len); dwell(2, p2, len); dwell(3, p3, len);
    quiet(ST + 3);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    m_holding = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; seg = 7'h7F; dig_en = 4'b0001; out_ready = 1'b0; ovr_clr = 1'b0;
    repeat (3) cyc();
    checks++; if (bcd !== '0) begin failures++; $display("FAIL reset_bcd got=%h exp=0", bcd); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    quiet(1);
    reset = 1'b0;
    model_reset();
    quiet(ST + 3);
  endtask

  task automatic test_basic();
    scan(7'h30, 7'h6D, 7'h79, 7'h33, 10);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (bcd !== 16'h4321) begin failures++; $display("FAIL basic_bcd got=%h exp=4321", bcd); end
    checks++; if (bcd !== m_bcd) begin failures++; $display("FAIL basic_model got=%h exp=%h", bcd, m_bcd); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL basic_ferr got=%b exp=0", frame_err); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b1 || bcd !== 16'h4321 || frame_err !== 1'b0) begin
        failures++;
        $display("FAIL basic_hold cyc=%0d got v=%b bcd=%h e=%b exp v=1 bcd=4321 e=0",
                 i, out_valid, bcd, frame_err);
      end
    end
    accept();
    cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_release got=%b exp=0", out_valid); end
  endtask

  task automatic test_glitch();
    dwell(0, 7'h7E, 10); dwell(1, 7'h30, 10);
    dwell(2, 7'h7E, 2); dwell(2, 7'h7F, 3); dwell(2, 7'h7E, 6);
    dwell(3, 7'h7E, 10);
    quiet(ST + 3);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL glitch_valid got=%b exp=1", out_valid); end
    checks++; if (bcd !== 16'h0010) begin failures++; $display("FAIL glitch_bcd got=%h exp=0010", bcd); end
    checks++; if (bcd !== m_bcd) begin failures++; $display("FAIL glitch_model got=%h exp=%h", bcd, m_bcd); end
    accept();
    cyc();
  endtask

  task automatic test_error();
    scan(7'h7E, 7'h01, 7'h6D, 7'h00, 8);
    checks++; if (bcd[7:4] !== 4'hE) begin failures++; $display("FAIL err_digit1 got=%h exp=e", bcd[7:4]); end
    checks++; if (bcd[15:12] !== 4'hF) begin failures++; $display("FAIL err_blank3 got=%h exp=f", bcd[15:12]); end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL err_flag got=%b exp=1", frame_err); end
    checks++; if (bcd !== m_bcd) begin failures++; $display("FAIL err_model got=%h exp=%h", bcd, m_bcd); end
    accept();
    cyc();
  endtask

  task automatic test_mid_start();
    dwell(2, 7'h5B, 8); dwell(3, 7'h5F, 8); dwell(0, 7'h70, 8); dwell(1, 7'h7F, 8);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midstart_early1 got=%b exp=0", out_valid); end
    dwell(2, 7'h7B, 8);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midstart_early2 got=%b exp=0", out_valid); end
    dwell(3, 7'h30, 8);
    quiet(ST + 3);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midstart_valid got=%b exp=1", out_valid); end
    checks++; if (bcd !== 16'h1987) begin failures++; $display("FAIL midstart_bcd got=%h exp=1987", bcd); end
    accept();
    cyc();
  endtask

  task automatic test_overrun();
    logic [4*N-1:0] held;
    scan(7'h33, 7'h5B, 7'h5F, 7'h70, 8);
    held = m_bcd;
    dwell(0, 7'h7F, 8); dwell(1, 7'h7B, 8);
    quiet(ST + 3);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    checks++; if (out_valid !== 1'b1 || bcd !== held) begin
      failures++; $display("FAIL ovr_hold got v=%b bcd=%h exp v=1 bcd=%h", out_valid, bcd, held);
    end
    ovr_clr = 1'b1; cyc(); ovr_clr = 1'b0; m_ovr = 0;
    checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL ovr_clear got=%b exp=%b", overrun, m_ovr); end
    // ovr_clr lands on the capture cycle itself: set must win.
    seg = 7'h7E; dig_en = 4'b0001;
    repeat (ST + 1) cyc();
    ovr_clr = 1'b1; cyc(); ovr_clr = 1'b0;
    repeat (2) cyc();
    model_capture(0, 7'h7E);
    quiet(2);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
    ovr_clr = 1'b1; cyc(); ovr_clr = 1'b0; m_ovr = 0;
    quiet(2);
    // Handshake on the digit-0 capture cycle: capture dropped, no overrun.
    seg = 7'h30; dig_en = 4'b0001;
    repeat (ST + 1) cyc();
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    m_holding = 0;
    repeat (3) cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hs_coincide_valid got=%b exp=0", out_valid); end
    checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL hs_coincide_ovr got=%b exp=%b", overrun, m_ovr); end
    dwell(1, 7'h6D, 8); dwell(2, 7'h79, 8); dwell(3, 7'h33, 8);
    quiet(ST + 3);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hs_dropped got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    scan(7'h30, 7'h30, 7'h30, 7'h30, 8);
    dwell(0, 7'h6D, 8);
    quiet(ST + 3);
    reset = 1'b1; cyc(); reset = 1'b0;
    model_reset();
    checks++; if (out_valid !== 1'b0 || bcd !== '0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL reset_hold got v=%b bcd=%h e=%b o=%b exp all 0",
                           out_valid, bcd, frame_err, overrun);
    end
    quiet(ST + 3);
    dwell(0, 7'h5B, 8); dwell(1, 7'h5F, 8);
    reset = 1'b1; cyc(); reset = 1'b0;
    model_reset();
    checks++; if (out_valid !== 1'b0 || bcd !== '0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL reset_collect got v=%b bcd=%h e=%b o=%b exp all 0",
                           out_valid, bcd, frame_err, overrun);
    end
    dwell(2, 7'h70, 8); dwell(3, 7'h7F, 8);
    quiet(ST + 3);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_abort got=%b exp=0", out_valid); end
    scan(7'h7B, 7'h7F, 7'h70, 7'h5F, 8);
    checks++; if (out_valid !== 1'b1 || bcd !== 16'h6789) begin
      failures++; $display("FAIL reset_next got v=%b bcd=%h exp v=1 bcd=6789", out_valid, bcd);
    end
    accept();
    cyc();
  endtask

  task automatic test_random();
    logic [6:0] p, gp;
    int r;
    for (int it = 0; it < 8; it++) begin
      for (int d = 0; d < N; d++) begin
        r = $urandom_range(0, 11);
        if (r < 10)       p = pat_tab[r];
        else if (r == 10) p = 7'h00;
        else begin
          do p = 7'($urandom); while (ref_decode(p) != 4'hE);
        end
        if ($urandom_range(0, 1) == 1) begin
          gp = p ^ 7'($urandom_range(1, 127));
          dwell(d, gp, $urandom_range(1, ST - 1));
        end
        dwell(d, p, $urandom_range(ST, ST + 6));
      end
      quiet(ST + 3);
      checks++; if (out_valid !== 1'(m_holding)) begin
        failures++; $display("FAIL rand_valid it=%0d got=%b exp=%b", it, out_valid, m_holding);
      end
      checks++; if (bcd !== m_bcd) begin
        failures++; $display("FAIL rand_bcd it=%0d got=%h exp=%h", it, bcd, m_bcd);
      end
      checks++; if (frame_err !== 1'(m_ferr)) begin
        failures++; $display("FAIL rand_ferr it=%0d got=%b exp=%b", it, frame_err, m_ferr);
      end
      accept();
      cyc();
      checks++; if (out_valid !== 1'b0) begin
        failures++; $display("FAIL rand_release it=%0d got=%b exp=0", it, out_valid);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_error();
    test_mid_start();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
